// File: rtl/output_capture_fifo_pkg.sv
// Shared types and helpers for the output capture FIFO.
// With OUTPUT_CAPTURE_TIMESTAMP_EN defined, every entry also carries an 8-bit cycle stamp.
package output_capture_pkg;

    localparam int DATA_W     = 8;
    localparam int MAX_PORTS  = 16;
    localparam int PORT_MAX_W = $clog2(MAX_PORTS);

    // The port field is sized for MAX_PORTS; the top narrows it to PORT_W on output.
    typedef struct packed {
        logic [PORT_MAX_W-1:0] port;
        logic [DATA_W-1:0]     data;
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
        logic [DATA_W-1:0]     stamp;
`endif
    } entry_t;

    function automatic logic [PORT_MAX_W-1:0] lowest_set(input logic [MAX_PORTS-1:0] mask);
        logic [PORT_MAX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = MAX_PORTS; i > 0; i--) begin
            if (mask[i-1]) idx = PORT_MAX_W'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_capture_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count; a push into
// a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/output_capture_fifo.sv
// Captures value changes on each 8-bit CPU output port as {port, value} FIFO entries.
// Define OUTPUT_CAPTURE_TIMESTAMP_EN to stamp entries with a free-running cycle count (pop_stamp).
module output_capture_fifo
    import output_capture_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int DEPTH     = 4,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*DATA_W-1:0]   outputs,
    input  logic                          pop_ready,
    output logic                          pop_valid,
    output logic [PORT_W-1:0]             pop_port,
    output logic [DATA_W-1:0]             pop_data,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic                          overflow
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
    ,
    output logic [DATA_W-1:0]             pop_stamp
`endif
);

    logic [NUM_PORTS-1:0][DATA_W-1:0] cur;
    logic [NUM_PORTS-1:0][DATA_W-1:0] prev;
    logic [NUM_PORTS-1:0][DATA_W-1:0] pend_val;
    logic [NUM_PORTS-1:0]             pending;
    logic [NUM_PORTS-1:0]             chg;
    logic [PORT_W-1:0]                sel;
    logic                             do_pop;
    logic                             do_push;
    logic                             empty;
    entry_t                           push_entry;
    entry_t                           head;

    assign cur     = outputs;
    assign sel     = PORT_W'(lowest_set(MAX_PORTS'(pending)));
    assign do_pop  = pop_valid && pop_ready;
    assign do_push = (|pending) && (!full || do_pop);

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) chg[i] = (cur[i] != prev[i]);
    end

`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
    logic [DATA_W-1:0]                stamp_cnt;
    logic [NUM_PORTS-1:0][DATA_W-1:0] pend_stamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stamp_cnt  <= '0;
            pend_stamp <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + 1'b1;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (chg[i]) pend_stamp[i] <= stamp_cnt;
            end
        end
    end
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.port = PORT_MAX_W'(sel);
        push_entry.data = pend_val[sel];
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
        push_entry.stamp = pend_stamp[sel];
`endif
    end

    // A change re-arms its pending bit even while the old value is being pushed;
    // only a change landing on an unpushed pending value is a loss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            pending  <= '0;
            pend_val <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= cur;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (chg[i]) begin
                    pending[i]  <= 1'b1;
                    pend_val[i] <= cur[i];
                    if (pending[i] && !(do_push && sel == PORT_W'(i))) overflow <= 1'b1;
                end else if (do_push && sel == PORT_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .push_data (push_entry),
        .pop       (do_pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign pop_valid = !empty;
    assign pop_port  = PORT_W'(head.port);
    assign pop_data  = head.data;
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
    assign pop_stamp = head.stamp;
`endif

endmodule

// File: tb/tb_output_capture_fifo.sv
// Self-checking bench for output_capture_fifo: cycle table plus hand-written corner sequences,
// popped entries checked against a scoreboard queue. Stamp checks need OUTPUT_CAPTURE_TIMESTAMP_EN.
module tb_output_capture_fifo;
    import output_capture_pkg::*;

    localparam int NUM_PORTS = 2;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] outputs = '0;
    logic        pop_ready = 1'b0;
    logic        pop_valid;
    logic [0:0]  pop_port;
    logic [7:0]  pop_data;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
    logic [7:0]  pop_stamp;
    logic [7:0]  tb_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:0] port;
        logic [7:0] data;
        logic [7:0] stamp;
        logic       cs;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [15:0] outv;
        logic        pr;
        logic        v;
        logic [2:0]  cnt;
        logic        fl;
        logic        ovf;
        logic [0:0]  hport;
        logic [7:0]  hdata;
    } vec_t;
    vec_t tbl[11];

    output_capture_fifo #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .outputs   (outputs),
        .pop_ready (pop_ready),
        .pop_valid (pop_valid),
        .pop_port  (pop_port),
        .pop_data  (pop_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
        ,
        .pop_stamp (pop_stamp)
`endif
    );

    always #5 clk = ~clk;

`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
    // Reference free-running cycle counter: the value the DUT will stamp at the next edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cnt <= 8'd0;
        else      tb_cnt <= tb_cnt + 8'd1;
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [0:0] p, input logic [7:0] d, input logic [7:0] s, input logic cs);
        ev_t e;
        e.port = p; e.data = d; e.stamp = s; e.cs = cs;
        sb.push_back(e);
    endtask

    // Called just before an edge at which pop_valid && pop_ready hold.
    task automatic check_head();
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: DUT head port %0d data %0h, none expected", pop_port, pop_data);
        end else begin
            e = sb.pop_front();
            chk("pop_port", pop_port, e.port);
            chk("pop_data", pop_data, e.data);
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
            if (e.cs) chk("pop_stamp", pop_stamp, e.stamp);
`endif
        end
    endtask

    task automatic drain(input int budget);
        pop_ready = 1'b1;
        for (int k = 0; k < budget && pop_valid; k++) begin
            check_head();
            step();
        end
        pop_ready = 1'b0;
        chk("drain_empty", pop_valid, 1'b0);
        chk("drain_count", count, 3'd0);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] last;

        //        outv      pr  v  cnt fl ovf hp  hd
        tbl[0]  = '{16'h0000, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{16'h0005, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{16'h0005, 0, 1, 1, 0, 0, 0, 8'h05};
        tbl[3]  = '{16'h0005, 0, 1, 1, 0, 0, 0, 8'h05};
        tbl[4]  = '{16'h0005, 1, 0, 0, 0, 0, 0, 8'h00};
        tbl[5]  = '{16'h3CAA, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[6]  = '{16'h3CAA, 0, 1, 1, 0, 0, 0, 8'hAA};
        tbl[7]  = '{16'h3CAA, 0, 1, 2, 0, 0, 0, 8'hAA};
        tbl[8]  = '{16'h3CAA, 1, 1, 1, 0, 0, 1, 8'h3C};
        tbl[9]  = '{16'h3CAA, 1, 0, 0, 0, 0, 0, 8'h00};
        tbl[10] = '{16'h3CAA, 0, 0, 0, 0, 0, 0, 8'h00};

        // Reset state
        step();
        step();
        chk("rst_valid", pop_valid, 1'b0);
        chk("rst_port", pop_port, 1'b0);
        chk("rst_data", pop_data, 8'h00);
        chk("rst_count", count, 3'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
        chk("rst_stamp", pop_stamp, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Table: latency, stable head, simultaneous two-port change
        last = 16'h0000;
        for (int i = 0; i < 11; i++) begin
            outputs   = tbl[i].outv;
            pop_ready = tbl[i].pr;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (tbl[i].outv[p*8 +: 8] != last[p*8 +: 8])
                    expect_ev(1'(p), tbl[i].outv[p*8 +: 8], 8'h00, 1'b0);
            end
            last = tbl[i].outv;
            if (pop_ready && pop_valid) check_head();
            step();
            chk($sformatf("tbl%0d_valid", i), pop_valid, tbl[i].v);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].fl);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_hport", i), pop_port, tbl[i].hport);
                chk($sformatf("tbl%0d_hdata", i), pop_data, tbl[i].hdata);
            end
        end
        pop_ready = 1'b0;

        // Fill to full, then coalesce two port1 changes into one pending value
        for (int k = 1; k <= 4; k++) begin
            outputs[7:0] = 8'(k);
            expect_ev(1'b0, 8'(k), 8'h00, 1'b0);
            step();
        end
        outputs[15:8] = 8'h11;
        step();
        chk("fill_count", count, 3'd4);
        chk("fill_full", full, 1'b1);
        chk("fill_ovf_clear", overflow, 1'b0);
        outputs[15:8] = 8'h22;
        expect_ev(1'b1, 8'h22, 8'h00, 1'b0);
        step();
        chk("coalesce_count", count, 3'd4);
        chk("coalesce_full", full, 1'b1);
        chk("coalesce_ovf", overflow, 1'b1);
        drain(12);

        // Full FIFO plus pending port0: one pop cycle makes room for the pending push
        for (int k = 0; k < 4; k++) begin
            outputs[15:8] = 8'h41 + 8'(k);
            expect_ev(1'b1, 8'h41 + 8'(k), 8'h00, 1'b0);
            step();
        end
        outputs[7:0] = 8'h77;
        expect_ev(1'b0, 8'h77, 8'h00, 1'b0);
        step();
        step();
        chk("bp_count", count, 3'd4);
        chk("bp_full", full, 1'b1);
        pop_ready = 1'b1;
        check_head();
        step();
        pop_ready = 1'b0;
        chk("simul_count", count, 3'd4);
        chk("simul_full", full, 1'b1);
        chk("simul_ovf_sticky", overflow, 1'b1);
        drain(12);

        // Asynchronous reset between edges with three entries queued
        for (int k = 0; k < 3; k++) begin
            outputs[7:0] = 8'h31 + 8'(k);
            step();
        end
        step();
        chk("pre_rst_count", count, 3'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 3'd0);
        chk("arst_valid", pop_valid, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_full", full, 1'b0);
        sb.delete();
        outputs = 16'h0100;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        expect_ev(1'b1, 8'h01, 8'h00, 1'b0);
        step();
        chk("post_rst_lat1", pop_valid, 1'b0);
        step();
        chk("post_rst_lat2", pop_valid, 1'b1);
        chk("post_rst_count", count, 3'd1);
        drain(4);

`ifdef OUTPUT_CAPTURE_TIMESTAMP_EN
        // Stamps straddling the 255->0 counter wrap
        for (int k = 0; k < 300 && tb_cnt != 8'd250; k++) step();
        if (tb_cnt != 8'd250) begin
            checks++;
            errors++;
            $display("FAIL stamp_sync250: counter %0d required 250", tb_cnt);
        end
        outputs[7:0] = 8'h5A;
        expect_ev(1'b0, 8'h5A, 8'd250, 1'b1);
        step();
        for (int k = 0; k < 300 && tb_cnt != 8'd3; k++) step();
        if (tb_cnt != 8'd3) begin
            checks++;
            errors++;
            $display("FAIL stamp_sync3: counter %0d required 3", tb_cnt);
        end
        outputs[7:0] = 8'hA5;
        expect_ev(1'b0, 8'hA5, 8'd3, 1'b1);
        step();
        step();
        chk("stamp_count", count, 3'd2);
        drain(6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_capture_fifo.md
Name: output_capture_fifo

Overview:
- Sits directly downstream of the CPU's `outputs` bus, next to the ROM on the motherboard.
- Watches each 8-bit output port for value changes and queues every change as a {port, value} event in a small FIFO.
- An external consumer (display/logger logic) drains the FIFO with a valid/ready handshake, so no output write is missed between slow game ticks.

Parameters:
- NUM_PORTS, 2, number of 8-bit output ports monitored.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PORT_W, $clog2(NUM_PORTS) (minimum 1), width of the port index (derived localparam).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived localparam).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- outputs  input  NUM_PORTS*8  CPU output bus; port i is bits [i*8+7:i*8].
- pop_ready  input  1  consumer accepts the head entry this cycle.
- pop_valid  output  1  FIFO non-empty; head entry is valid.
- pop_port  output  PORT_W  port index of the head entry.
- pop_data  output  8  value of the head entry.
- count  output  CNT_W  number of entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; a pending change was overwritten before it could be queued.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - prev[] (last sampled bytes) = 0, pending mask = 0, pend_val[] = 0;
  - FIFO pointers = 0, overflow = 0.
  - Outputs: pop_valid=0, pop_port=0, pop_data=0, count=0, full=0.
- Reset mid-operation discards all queued and pending events. After release, any nonzero port generates an event because prev = 0.
- Detect stage, every edge:
  - prev[i] <= outputs byte i.
  - chg[i] = (byte i != prev[i]).
  - If chg[i]: pending[i] <= 1 and pend_val[i] <= new byte.
  - If chg[i] and pending[i] is already set and not being pushed this edge: new value replaces the old one (coalesced) and overflow <= 1.
- Push stage, each edge at most one push:
  - Selects the lowest-index port with pending set.
  - Pushes only if !full, or if full and a pop happens the same edge.
  - On push: writes {index, pend_val}, clears that pending bit. A change detected on the same port at the same edge re-sets the bit with the new value; no overflow.
- Pop:
  - Occurs when pop_valid && pop_ready.
  - pop_port/pop_data come combinationally from the head entry; they are stable while pop_valid && !pop_ready.
  - pop_ready with an empty FIFO is ignored.
- Simultaneous push and pop: count is unchanged; allowed when full or when count==1.
- Full: pending bits persist (backpressure), no data is dropped except by coalescing.
- Pointers wrap modulo DEPTH.
- Latency: a byte change presented before edge E0 is pending after E0, is written at E1, and pop_valid rises after E1 (2 cycles) when the FIFO was empty.
- Sustained throughput: 1 event/cycle.
- Multiple ports changing together are queued in ascending index order on consecutive cycles.

Optional Feature:
- Macro: OUTPUT_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Free-running 8-bit cycle counter, reset 0, wraps 255->0.
  - pend_stamp[i] is captured with pend_val[i], including on overwrite.
  - Each FIFO entry carries the stamp; extra output pop_stamp (8) shows the head entry's stamp, reset 0.
- Undefined: no counter, no stamp storage, port pop_stamp absent. All other behaviour is identical.

Decomposition:
- Package output_capture_pkg holds:
  - the entry struct typedef {port, data[, stamp]};
  - the port-selection helper function (lowest set bit);
  - DATA_W=8.
- One sub-module, sync_fifo:
  - parameters DEPTH and entry type width;
  - push/pop, count/full/empty, wrap-around pointers.
  - Change detection, the pending registers and the arbiter stay in the top module.

Test Plan:
- Reset with outputs=16'h0000, then set port0=8'h05 (pop_ready=0) -> pop_valid rises 2 cycles later with pop_port=0, pop_data=8'h05, count=1.
- Change port0->8'hAA and port1->8'h3C on the same cycle -> entries pop in order {0,AA} then {1,3C}; count reaches 2; overflow=0.
- pop_ready=0, drive 4 distinct changes to fill DEPTH=4, then change port1 twice more (8'h11 then 8'h22) -> full=1, overflow=1. After popping all four entries, next entry is {1,22}.
- Full FIFO with pending port0 change, assert pop_ready for one cycle -> simultaneous pop+push, count stays 4, new tail is the pending value.
- Assert rst low asynchronously between edges while count=3 -> count=0, pop_valid=0, overflow=0 immediately. After release with outputs=16'h0100, entry {1,01} appears.
- With OUTPUT_CAPTURE_TIMESTAMP_EN: change port0 at counter value 8'd250, then at 8'd3 after wrap -> pop_stamp reads 250 then 3.
